flag_branch_unit: RTL
=====================

// Module: flag_branch_unit
// PURPOSE
//   Consumer side of the cmp block. Latches cmp result flags {N,Z,C,V} into a flag register.
//   Evaluates 4-bit branch conditions against those flags.
//   Returns taken/target through a registered valid/ready response stage that feeds fetch redirect.
// PARAMETERS
//   WIDTH      32   data width of cmp_out and br_target
//   CNT_WIDTH  16   width of the saturating branch statistics counters
// PORTS
//   clk           in   1          single clock, rising edge
//   rst           in   1          synchronous, active-high reset
//   flag_we       in   1          capture cmp flags this cycle
//   cmp_out       in   WIDTH      cmp difference In1-In2
//   cmp_carry     in   1          cmp carry-out; 1 = no borrow (In1 >= In2 unsigned)
//   cmp_ovf       in   1          cmp signed overflow
//   br_valid      in   1          branch request valid
//   br_ready      out  1          branch request accepted when valid & ready
//   br_cond       in   4          condition code
//   br_target     in   WIDTH      branch target
//   rsp_valid     out  1          response valid
//   rsp_ready     in   1          downstream accepts response
//   rsp_taken     out  1          condition true
//   rsp_target    out  WIDTH      br_target if taken, else 0
//   flags         out  4          current flag register {N,Z,C,V}
//   cnt_total     out  CNT_WIDTH  accepted branches, saturating
//   cnt_taken     out  CNT_WIDTH  taken branches, saturating
// BEHAVIOUR
//   - Reset: flags=4'b0000, rsp_valid=0, rsp_taken=0, rsp_target=0, cnt_total=0, cnt_taken=0.
//     A reset during a pending response discards that response.
//   - Flag capture on flag_we:
//       N=cmp_out[WIDTH-1], Z=(cmp_out==0), C=cmp_carry, V=cmp_ovf.
//       Visible on flags the next cycle.
//   - Output stage: one entry.
//       br_ready = (!rsp_valid | rsp_ready) & stall_ok.
//       On accept, rsp_* loads next cycle (latency 1).
//       rsp_valid clears on rsp_ready when no new accept occurs.
//       rsp_* holds stable while rsp_valid & !rsp_ready.
//   - Condition codes:
//       0 EQ Z           1 NE !Z          2 CS C           3 CC !C
//       4 MI N           5 PL !N          6 VS V           7 VC !V
//       8 HI C&!Z        9 LS !C|Z        10 GE N==V       11 LT N!=V
//       12 GT !Z&(N==V)  13 LE Z|(N!=V)   14 AL 1          15 NV 0
//   - Counters: each accept increments cnt_total; each taken accept increments cnt_taken.
//     Both saturate at all-ones and never wrap.
//   - Simultaneous flag_we & br_valid: governed by FLAG_FWD_EN, see CONFIGURATION.
//   - Back-to-back accepts at full rate are allowed when rsp_ready is held high.
// CONFIGURATION
//   FLAG_FWD_EN defined:
//     stall_ok=1.
//     A branch accepted in the same cycle as flag_we evaluates against the incoming cmp flags (forwarded).
//   FLAG_FWD_EN undefined:
//     stall_ok=!flag_we, so br_ready=0 in any cycle with flag_we.
//     The branch is accepted the next cycle against the registered, updated flags.
//     Adds 1 cycle per such collision.
//   Both builds produce identical rsp_taken for identical instruction order.
// STRUCTURE
//   - Package cond_pkg:
//       localparams COND_EQ..COND_NV (4'd0..4'd15)
//       flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//   - Sub-module cond_eval (combinational): inputs flags[3:0] and cond[3:0], output take.
//     Instantiated once.
//   - Top level holds the flag register, forward mux, response register and counters.
// TESTING
//   1. flag_we with out=32'hFFFFFFFB, carry=0, ovf=0 (10-15); then LT, CC, NE
//      -> flags=4'b1000, all taken; GE not taken.
//   2. flag_we with out=0, carry=1, ovf=0 (5-5); then EQ, HI, LS
//      -> taken=1,0,1; rsp_target=br_target only on taken responses.
//   3. flag_we with out=32'hFFFFFFFE, carry=0, ovf=1 (7FFFFFFF-(-7FFFFFFF)); then GT, MI
//      -> GT taken, MI taken, VS taken.
//   4. rsp_ready=0 for 5 cycles with br_valid=1
//      -> one response held stable, br_ready=0, cnt_total=1; then drains 1 response per cycle.
//   5. flag_we & br_valid same cycle, cond EQ, new Z=1, old Z=0
//      -> FWD_EN: accepted that cycle, taken.
//      -> no FWD_EN: br_ready=0, accepted next cycle, taken.
//   6. Force cnt_taken to max with AL branches -> stays 16'hFFFF.
//      Assert rst with rsp_valid=1 -> all outputs zero next cycle.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the flag/branch unit: condition code encodings
// and bit positions of {N,Z,C,V} inside the 4-bit flag word.
package cond_pkg;

    typedef logic [3:0] cond_t;
    typedef logic [3:0] flags_t;

    localparam cond_t COND_EQ = 4'd0;
    localparam cond_t COND_NE = 4'd1;
    localparam cond_t COND_CS = 4'd2;
    localparam cond_t COND_CC = 4'd3;
    localparam cond_t COND_MI = 4'd4;
    localparam cond_t COND_PL = 4'd5;
    localparam cond_t COND_VS = 4'd6;
    localparam cond_t COND_VC = 4'd7;
    localparam cond_t COND_HI = 4'd8;
    localparam cond_t COND_LS = 4'd9;
    localparam cond_t COND_GE = 4'd10;
    localparam cond_t COND_LT = 4'd11;
    localparam cond_t COND_GT = 4'd12;
    localparam cond_t COND_LE = 4'd13;
    localparam cond_t COND_AL = 4'd14;
    localparam cond_t COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator: decides whether a 4-bit
// condition code holds for a given {N,Z,C,V} flag word.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       take
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition code against the flag bits.
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c & !z;
            COND_LS: take = !c | z;
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z & (n == v);
            COND_LE: take = z | (n != v);
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus branch resolution for fetch redirect.
// Captures cmp flags, evaluates branch conditions and returns the result
// through a one-entry registered response stage with saturating counters.
// Optional macro FLAG_FWD_EN: when defined, a branch arriving in the same
// cycle as flag_we is evaluated against the incoming cmp flags; when
// undefined, such a branch is held off one cycle (br_ready=0) and then
// evaluated against the freshly registered flags.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; a producer keeps valid and payload stable until that edge, and
// the response stage keeps rsp_* stable while rsp_valid & !rsp_ready.
module flag_branch_unit
    import cond_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic [WIDTH-1:0]     cmp_out,
    input  logic                 cmp_carry,
    input  logic                 cmp_ovf,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [3:0]           br_cond,
    input  logic [WIDTH-1:0]     br_target,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_taken,
    output logic [WIDTH-1:0]     rsp_target,
    output logic [3:0]           flags,
    output logic [CNT_WIDTH-1:0] cnt_total,
    output logic [CNT_WIDTH-1:0] cnt_taken
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0] flag_q;
    logic [3:0] cmp_flags;
    logic [3:0] eval_flags;
    logic       stall_ok;
    logic       accept;
    logic       take;

    // Flag word as produced by the cmp block this cycle.
    always_comb begin
        cmp_flags         = 4'b0000;
        cmp_flags[FLAG_N] = cmp_out[WIDTH-1];
        cmp_flags[FLAG_Z] = (cmp_out == '0);
        cmp_flags[FLAG_C] = cmp_carry;
        cmp_flags[FLAG_V] = cmp_ovf;
    end

`ifdef FLAG_FWD_EN
    // Forward incoming flags to a branch accepted alongside flag_we.
    always_comb begin
        stall_ok   = 1'b1;
        eval_flags = flag_we ? cmp_flags : flag_q;
    end
`else
    // Hold the branch off while flags are being written; use registered flags.
    always_comb begin
        stall_ok   = !flag_we;
        eval_flags = flag_q;
    end
`endif

    assign br_ready = (!rsp_valid | rsp_ready) & stall_ok;
    assign accept   = br_valid & br_ready;
    assign flags    = flag_q;

    cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (br_cond),
        .take  (take)
    );

    // Flag register: updated from the cmp block on flag_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 4'b0000;
        end else if (flag_we) begin
            flag_q <= cmp_flags;
        end
    end

    // One-entry response stage: load on accept, clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_taken  <= 1'b0;
            rsp_target <= '0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_taken  <= take;
            rsp_target <= take ? br_target : '0;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Saturating statistics: every accept, and every taken accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_total <= '0;
            cnt_taken <= '0;
        end else if (accept) begin
            if (cnt_total != CNT_MAX) begin
                cnt_total <= cnt_total + CNT_ONE;
            end
            if (take && (cnt_taken != CNT_MAX)) begin
                cnt_taken <= cnt_taken + CNT_ONE;
            end
        end
    end

endmodule
